axil_arbiter_2to1: RTL and testbench
====================================

# axil_arbiter_2to1

Two-requester AXI4-Lite arbiter that shares one downstream AXI4-Lite port between the host data port (requester 0) and the instruction-fetch port (requester 1), ahead of the address-decoding interconnect. Read and write paths arbitrate independently. Each grant is held for one complete transaction (AW+W+B or AR+R), so responses always return to the requester that issued them. Ties resolve round-robin, or by fixed priority when round-robin is compiled out.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; WSTRB is DATA_W/8
- PRIO_MASTER, 0, requester index that wins ties when ARB_ROUND_ROBIN_EN is undefined
- ACLK  in  1  clock
- ARESETN  in  1  reset, synchronous, active-low
- S0_AWADDR/AWPROT/AWVALID  in  ADDR_W/3/1  requester 0 write address; S0_AWREADY out 1
- S0_WDATA/WSTRB/WVALID  in  DATA_W/4/1  requester 0 write data; S0_WREADY out 1
- S0_BRESP/BVALID  out  2/1  requester 0 write response; S0_BREADY in 1
- S0_ARADDR/ARPROT/ARVALID  in  ADDR_W/3/1  requester 0 read address; S0_ARREADY out 1
- S0_RDATA/RRESP/RVALID  out  DATA_W/2/1  requester 0 read data; S0_RREADY in 1
- S1_* identical set for requester 1 (instruction fetch)
- M_AW*/M_W*/M_B*/M_AR*/M_R*  mirrored directions  same widths  downstream port to interconnect
- GNT_W  out  2  one-hot write grant, 0 when idle
- GNT_R  out  2  one-hot read grant, 0 when idle

## Operation
- Write FSM: W_IDLE -> W_XFER -> W_RESP -> W_IDLE.
  - W_IDLE: a request is Sx_AWVALID. Pick a winner, register GNT_W, go to W_XFER.
  - W_XFER: forward the winner's AW and W channels. Track the flags aw_done and w_done; either order or the same cycle is legal. Go to W_RESP once both handshakes have completed.
  - W_RESP: forward B. On the M_BVALID&M_BREADY cycle, clear GNT_W, record last_w, return to W_IDLE.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: a request is Sx_ARVALID.
  - R_ADDR: leave on the AR handshake.
  - R_DATA: leave on the R handshake, recording last_r.
- Pick rule:
  - Only one requester active: it wins.
  - Both active: the one not recorded in last_x wins (round-robin).
  - last_x resets to 1, so requester 0 wins the first tie.
- Non-granted requester: READY outputs and B/RVALID held 0.
- Downstream channel gating:
  - M_AWVALID is forced 0 after aw_done, and M_WVALID after w_done. A requester holding VALID is never forwarded twice.
  - Downstream VALIDs are 0 in the IDLE states.
  - Downstream address/data/strobe/prot outputs are 0 when no grant is held.
- Write and read paths are fully concurrent, e.g. requester 0 writes while requester 1 reads.
- No decode, no error generation: BRESP/RRESP pass through unchanged.

## Timing
- Reset values: FSMs in IDLE, GNT_W=GNT_R=0, every VALID/READY output 0, all data/address outputs 0, last_w=last_r=1.
- Arbitration latency: request seen at cycle N in IDLE -> downstream VALID asserted at N+1.
- Forward path is combinational from the grant register:
  - Sx_AWREADY=M_AWREADY&~aw_done, Sx_WREADY=M_WREADY&~w_done for the granted requester.
  - R/B data, resp and valid are combinational pass-through; no buffering.
- Back-to-back: the response handshake at N puts the FSM in IDLE at N+1, with the new grant effective at N+2. This is a one-cycle bubble per transaction.
- Requester dropping VALID before handshake violates AXI and is not handled.
- ARESETN low mid-transaction: all state returns to reset values next edge, in-flight transaction abandoned. Requesters and slaves are reset by the same ARESETN.

## Configuration
- ARB_ROUND_ROBIN_EN defined: tie resolves to the requester not served last (last_w/last_r registers present).
- Undefined:
  - Tie always resolves to PRIO_MASTER.
  - last_w/last_r removed.
  - Starvation of the other requester under continuous contention is accepted behaviour.

## Structure
- Package axil_arb_pkg holds:
  - write/read FSM state enums;
  - localparams REQ_HOST=0, REQ_IMEM=1;
  - AXI response codes OKAY=2'b00, SLVERR=2'b10.
- Sub-module axil_arb_pick: 2-way combinational picker (req[1:0], last, prio -> one-hot gnt). Instantiated once per direction; the macro selects its rule.

## Test plan
- S0 write 0x2000_0010 data 0xDEADBEEF WSTRB 0xF, slave BRESP OKAY:
  - M_AWVALID rises one cycle after S0_AWVALID, GNT_W=2'b01;
  - S0_BVALID pulses with OKAY, S1_BVALID stays 0.
- S0 and S1 both assert ARVALID after reset, repeated three times:
  - grant order S0, S1, S0 (GNT_R 01,10,01);
  - RDATA 0x1111_1111/0x2222_2222 route to the correct requester.
- S0 write and S1 read 0x4000_0000 issued in the same cycle: GNT_W=01 and GNT_R=10 simultaneously, both complete independently.
- S0 WVALID two cycles before AWVALID, slave WREADY before AWREADY: exactly one M_W and one M_AW handshake, then W_RESP, then single B to S0.
- ARESETN low while in W_XFER with S1 granted: next cycle GNT_W=0, M_AWVALID=M_WVALID=0, all READY outputs 0.
- ARB_ROUND_ROBIN_EN undefined, PRIO_MASTER=0, continuous ARVALID from both: S0 granted every transaction, S1 never granted.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite arbiter.
// Tie-break rule is selected by ARB_ROUND_ROBIN_EN in axil_arb_pick.
package axil_arb_pkg;

    localparam int unsigned REQ_HOST = 0;
    localparam int unsigned REQ_IMEM = 1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

endpackage

// File: rtl/axil_arb_pick.sv
// Two-way combinational picker producing a one-hot grant.
// ARB_ROUND_ROBIN_EN: ties go to the requester not served last; otherwise to prio.
module axil_arb_pick
    import axil_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio,
    output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
    logic unused_prio;
    assign unused_prio = prio;
`else
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        gnt = '0;
        case (req)
            2'b01: gnt[REQ_HOST] = 1'b1;
            2'b10: gnt[REQ_IMEM] = 1'b1;
            2'b11: begin
`ifdef ARB_ROUND_ROBIN_EN
                // last names the requester served previously; the other one wins
                if (last) gnt[REQ_HOST] = 1'b1;
                else      gnt[REQ_IMEM] = 1'b1;
`else
                if (prio) gnt[REQ_IMEM] = 1'b1;
                else      gnt[REQ_HOST] = 1'b1;
`endif
            end
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/axil_arbiter_2to1.sv
// 2:1 AXI4-Lite arbiter; independent read and write paths, grant held per transaction.
// ARB_ROUND_ROBIN_EN selects round-robin ties (else fixed PRIO_MASTER).
module axil_arbiter_2to1
    import axil_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PRIO_MASTER = 0
) (
    input  logic                ACLK,
    input  logic                ARESETN,

    input  logic [ADDR_W-1:0]   S0_AWADDR,
    input  logic [2:0]          S0_AWPROT,
    input  logic                S0_AWVALID,
    output logic                S0_AWREADY,
    input  logic [DATA_W-1:0]   S0_WDATA,
    input  logic [DATA_W/8-1:0] S0_WSTRB,
    input  logic                S0_WVALID,
    output logic                S0_WREADY,
    output logic [1:0]          S0_BRESP,
    output logic                S0_BVALID,
    input  logic                S0_BREADY,
    input  logic [ADDR_W-1:0]   S0_ARADDR,
    input  logic [2:0]          S0_ARPROT,
    input  logic                S0_ARVALID,
    output logic                S0_ARREADY,
    output logic [DATA_W-1:0]   S0_RDATA,
    output logic [1:0]          S0_RRESP,
    output logic                S0_RVALID,
    input  logic                S0_RREADY,

    input  logic [ADDR_W-1:0]   S1_AWADDR,
    input  logic [2:0]          S1_AWPROT,
    input  logic                S1_AWVALID,
    output logic                S1_AWREADY,
    input  logic [DATA_W-1:0]   S1_WDATA,
    input  logic [DATA_W/8-1:0] S1_WSTRB,
    input  logic                S1_WVALID,
    output logic                S1_WREADY,
    output logic [1:0]          S1_BRESP,
    output logic                S1_BVALID,
    input  logic                S1_BREADY,
    input  logic [ADDR_W-1:0]   S1_ARADDR,
    input  logic [2:0]          S1_ARPROT,
    input  logic                S1_ARVALID,
    output logic                S1_ARREADY,
    output logic [DATA_W-1:0]   S1_RDATA,
    output logic [1:0]          S1_RRESP,
    output logic                S1_RVALID,
    input  logic                S1_RREADY,

    output logic [ADDR_W-1:0]   M_AWADDR,
    output logic [2:0]          M_AWPROT,
    output logic                M_AWVALID,
    input  logic                M_AWREADY,
    output logic [DATA_W-1:0]   M_WDATA,
    output logic [DATA_W/8-1:0] M_WSTRB,
    output logic                M_WVALID,
    input  logic                M_WREADY,
    input  logic [1:0]          M_BRESP,
    input  logic                M_BVALID,
    output logic                M_BREADY,
    output logic [ADDR_W-1:0]   M_ARADDR,
    output logic [2:0]          M_ARPROT,
    output logic                M_ARVALID,
    input  logic                M_ARREADY,
    input  logic [DATA_W-1:0]   M_RDATA,
    input  logic [1:0]          M_RRESP,
    input  logic                M_RVALID,
    output logic                M_RREADY,

    output logic [1:0]          GNT_W,
    output logic [1:0]          GNT_R
);

    w_state_t   w_state;
    r_state_t   r_state;
    logic [1:0] gnt_w, gnt_r;
    logic [1:0] pick_w, pick_r;
    logic       aw_done, w_done;
    logic       last_w_q, last_r_q;
    logic       prio_bit;

    assign prio_bit = (PRIO_MASTER == REQ_IMEM);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_w, last_r;
    assign last_w_q = last_w;
    assign last_r_q = last_r;
`else
    assign last_w_q = 1'b1;
    assign last_r_q = 1'b1;
`endif

    axil_arb_pick u_pick_w (
        .req  ({S1_AWVALID, S0_AWVALID}),
        .last (last_w_q),
        .prio (prio_bit),
        .gnt  (pick_w)
    );

    axil_arb_pick u_pick_r (
        .req  ({S1_ARVALID, S0_ARVALID}),
        .last (last_r_q),
        .prio (prio_bit),
        .gnt  (pick_r)
    );

    logic s0w, s1w, s0r, s1r;
    logic w_xfer, w_resp, r_addr, r_data;
    logic aw_valid_sel, w_valid_sel, b_ready_sel, ar_valid_sel, r_ready_sel;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign s0w    = gnt_w[REQ_HOST];
    assign s1w    = gnt_w[REQ_IMEM];
    assign s0r    = gnt_r[REQ_HOST];
    assign s1r    = gnt_r[REQ_IMEM];
    assign w_xfer = (w_state == W_XFER);
    assign w_resp = (w_state == W_RESP);
    assign r_addr = (r_state == R_ADDR);
    assign r_data = (r_state == R_DATA);

    always_comb begin
        M_AWADDR     = '0;
        M_AWPROT     = '0;
        M_WDATA      = '0;
        M_WSTRB      = '0;
        aw_valid_sel = 1'b0;
        w_valid_sel  = 1'b0;
        b_ready_sel  = 1'b0;
        if (s0w) begin
            M_AWADDR     = S0_AWADDR;
            M_AWPROT     = S0_AWPROT;
            M_WDATA      = S0_WDATA;
            M_WSTRB      = S0_WSTRB;
            aw_valid_sel = S0_AWVALID;
            w_valid_sel  = S0_WVALID;
            b_ready_sel  = S0_BREADY;
        end else if (s1w) begin
            M_AWADDR     = S1_AWADDR;
            M_AWPROT     = S1_AWPROT;
            M_WDATA      = S1_WDATA;
            M_WSTRB      = S1_WSTRB;
            aw_valid_sel = S1_AWVALID;
            w_valid_sel  = S1_WVALID;
            b_ready_sel  = S1_BREADY;
        end
    end

    always_comb begin
        M_ARADDR     = '0;
        M_ARPROT     = '0;
        ar_valid_sel = 1'b0;
        r_ready_sel  = 1'b0;
        if (s0r) begin
            M_ARADDR     = S0_ARADDR;
            M_ARPROT     = S0_ARPROT;
            ar_valid_sel = S0_ARVALID;
            r_ready_sel  = S0_RREADY;
        end else if (s1r) begin
            M_ARADDR     = S1_ARADDR;
            M_ARPROT     = S1_ARPROT;
            ar_valid_sel = S1_ARVALID;
            r_ready_sel  = S1_RREADY;
        end
    end

    // Completed channels are masked so a requester still holding VALID is not re-forwarded
    assign M_AWVALID = w_xfer & ~aw_done & aw_valid_sel;
    assign M_WVALID  = w_xfer & ~w_done & w_valid_sel;
    assign M_BREADY  = w_resp & b_ready_sel;
    assign M_ARVALID = r_addr & ar_valid_sel;
    assign M_RREADY  = r_data & r_ready_sel;

    assign aw_hs = M_AWVALID & M_AWREADY;
    assign w_hs  = M_WVALID & M_WREADY;
    assign b_hs  = M_BVALID & M_BREADY;
    assign ar_hs = M_ARVALID & M_ARREADY;
    assign r_hs  = M_RVALID & M_RREADY;

    assign S0_AWREADY = s0w & w_xfer & M_AWREADY & ~aw_done;
    assign S1_AWREADY = s1w & w_xfer & M_AWREADY & ~aw_done;
    assign S0_WREADY  = s0w & w_xfer & M_WREADY & ~w_done;
    assign S1_WREADY  = s1w & w_xfer & M_WREADY & ~w_done;
    assign S0_BVALID  = s0w & w_resp & M_BVALID;
    assign S1_BVALID  = s1w & w_resp & M_BVALID;
    assign S0_BRESP   = s0w ? M_BRESP : '0;
    assign S1_BRESP   = s1w ? M_BRESP : '0;

    assign S0_ARREADY = s0r & r_addr & M_ARREADY;
    assign S1_ARREADY = s1r & r_addr & M_ARREADY;
    assign S0_RVALID  = s0r & r_data & M_RVALID;
    assign S1_RVALID  = s1r & r_data & M_RVALID;
    assign S0_RDATA   = s0r ? M_RDATA : '0;
    assign S1_RDATA   = s1r ? M_RDATA : '0;
    assign S0_RRESP   = s0r ? M_RRESP : '0;
    assign S1_RRESP   = s1r ? M_RRESP : '0;

    assign GNT_W = gnt_w;
    assign GNT_R = gnt_r;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            gnt_w   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_w  <= 1'b1;
`endif
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (pick_w != 2'b00) begin
                        gnt_w   <= pick_w;
                        w_state <= W_XFER;
                    end
                end
                W_XFER: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done | aw_hs) & (w_done | w_hs)) w_state <= W_RESP;
                end
                W_RESP: begin
                    if (b_hs) begin
                        gnt_w   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_w  <= gnt_w[REQ_IMEM];
`endif
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    gnt_w   <= '0;
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            gnt_r   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_r  <= 1'b1;
`endif
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (pick_r != 2'b00) begin
                        gnt_r   <= pick_r;
                        r_state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (ar_hs) r_state <= R_DATA;
                end
                R_DATA: begin
                    if (r_hs) begin
                        gnt_r   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_r  <= gnt_r[REQ_IMEM];
`endif
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    gnt_r   <= '0;
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Directed bench for axil_arbiter_2to1: table-driven read arbitration plus write/reset sequences.
// Tie expectations follow ARB_ROUND_ROBIN_EN (defined: round-robin, else PRIO_MASTER=0).
module tb_axil_arbiter_2to1;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] S0_AWADDR, S1_AWADDR, S0_WDATA, S1_WDATA, S0_ARADDR, S1_ARADDR;
    logic [2:0]  S0_AWPROT, S1_AWPROT, S0_ARPROT, S1_ARPROT;
    logic [3:0]  S0_WSTRB, S1_WSTRB;
    logic        S0_AWVALID, S1_AWVALID, S0_WVALID, S1_WVALID, S0_BREADY, S1_BREADY;
    logic        S0_ARVALID, S1_ARVALID, S0_RREADY, S1_RREADY;
    logic        S0_AWREADY, S1_AWREADY, S0_WREADY, S1_WREADY, S0_BVALID, S1_BVALID;
    logic        S0_ARREADY, S1_ARREADY, S0_RVALID, S1_RVALID;
    logic [1:0]  S0_BRESP, S1_BRESP, S0_RRESP, S1_RRESP;
    logic [31:0] S0_RDATA, S1_RDATA;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic [2:0]  M_AWPROT, M_ARPROT;
    logic [3:0]  M_WSTRB;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [1:0]  M_BRESP, M_RRESP;
    logic [1:0]  GNT_W, GNT_R;

    always #5 ACLK = ~ACLK;

    axil_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .PRIO_MASTER(0)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S0_AWADDR(S0_AWADDR), .S0_AWPROT(S0_AWPROT), .S0_AWVALID(S0_AWVALID), .S0_AWREADY(S0_AWREADY),
        .S0_WDATA(S0_WDATA), .S0_WSTRB(S0_WSTRB), .S0_WVALID(S0_WVALID), .S0_WREADY(S0_WREADY),
        .S0_BRESP(S0_BRESP), .S0_BVALID(S0_BVALID), .S0_BREADY(S0_BREADY),
        .S0_ARADDR(S0_ARADDR), .S0_ARPROT(S0_ARPROT), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
        .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
        .S1_AWADDR(S1_AWADDR), .S1_AWPROT(S1_AWPROT), .S1_AWVALID(S1_AWVALID), .S1_AWREADY(S1_AWREADY),
        .S1_WDATA(S1_WDATA), .S1_WSTRB(S1_WSTRB), .S1_WVALID(S1_WVALID), .S1_WREADY(S1_WREADY),
        .S1_BRESP(S1_BRESP), .S1_BVALID(S1_BVALID), .S1_BREADY(S1_BREADY),
        .S1_ARADDR(S1_ARADDR), .S1_ARPROT(S1_ARPROT), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
        .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
        .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .GNT_W(GNT_W), .GNT_R(GNT_R)
    );

    int passed = 0;
    int total  = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt  = 0;

    always @(posedge ACLK) begin
        if (M_AWVALID && M_AWREADY) aw_hs_cnt++;
        if (M_WVALID && M_WREADY)   w_hs_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    typedef struct {
        logic        s0v;
        logic        s1v;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [1:0]  exp_gnt;
    } rd_vec_t;

    rd_vec_t tbl [8];

    initial begin
        logic [31:0] exp_addr, w_rdata;
        logic [1:0]  w_rresp;
        logic        w_arready, l_arready, w_rvalid, l_rvalid;
        int          aw0, w0;

`ifdef ARB_ROUND_ROBIN_EN
        tbl[0] = '{1'b1, 1'b1, 32'h1111_1111, 2'b00, 2'b01};
        tbl[1] = '{1'b1, 1'b1, 32'h2222_2222, 2'b10, 2'b10};
        tbl[2] = '{1'b1, 1'b1, 32'h1111_1111, 2'b00, 2'b01};
        tbl[3] = '{1'b0, 1'b1, 32'h2222_2222, 2'b00, 2'b10};
        tbl[4] = '{1'b1, 1'b0, 32'h3333_3333, 2'b00, 2'b01};
        tbl[5] = '{1'b1, 1'b1, 32'h4444_4444, 2'b00, 2'b10};
        tbl[6] = '{1'b1, 1'b1, 32'h5555_5555, 2'b10, 2'b01};
        tbl[7] = '{1'b0, 1'b1, 32'h6666_6666, 2'b00, 2'b10};
`else
        // S1 starves while S0 keeps requesting; it is drained once S0 stops
        tbl[0] = '{1'b1, 1'b1, 32'h1111_1111, 2'b00, 2'b01};
        tbl[1] = '{1'b1, 1'b1, 32'h1111_1111, 2'b10, 2'b01};
        tbl[2] = '{1'b1, 1'b1, 32'h1111_1111, 2'b00, 2'b01};
        tbl[3] = '{1'b0, 1'b1, 32'h2222_2222, 2'b00, 2'b10};
        tbl[4] = '{1'b1, 1'b0, 32'h3333_3333, 2'b00, 2'b01};
        tbl[5] = '{1'b1, 1'b1, 32'h4444_4444, 2'b00, 2'b01};
        tbl[6] = '{1'b1, 1'b1, 32'h5555_5555, 2'b10, 2'b01};
        tbl[7] = '{1'b0, 1'b1, 32'h6666_6666, 2'b00, 2'b10};
`endif

        ARESETN = 1'b0;
        {S0_AWADDR, S1_AWADDR, S0_WDATA, S1_WDATA, S0_ARADDR, S1_ARADDR} = '0;
        {S0_AWPROT, S1_AWPROT, S0_ARPROT, S1_ARPROT, S0_WSTRB, S1_WSTRB} = '0;
        {S0_AWVALID, S1_AWVALID, S0_WVALID, S1_WVALID, S0_ARVALID, S1_ARVALID} = '0;
        {S0_BREADY, S1_BREADY, S0_RREADY, S1_RREADY} = 4'b1111;
        {M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID} = '0;
        M_BRESP = 2'b00; M_RRESP = 2'b00; M_RDATA = '0;

        // reset state
        repeat (2) step();
        chk("rst_gnt_w", GNT_W, 0);
        chk("rst_gnt_r", GNT_R, 0);
        chk("rst_valids", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}, 0);
        chk("rst_readys", {S0_AWREADY, S0_WREADY, S0_ARREADY, S1_AWREADY, S1_WREADY, S1_ARREADY}, 0);
        chk("rst_m_addr", M_AWADDR | M_ARADDR | M_WDATA, 0);
        ARESETN = 1'b1;

        // read arbitration table
        for (int i = 0; i < 8; i++) begin
            S0_ARVALID = tbl[i].s0v;
            S1_ARVALID = tbl[i].s1v;
            S0_ARADDR  = 32'h1000_0000 + 32'(i);
            S1_ARADDR  = 32'h4000_0100 + 32'(i);
            step();
            exp_addr = (tbl[i].exp_gnt == 2'b01) ? S0_ARADDR : S1_ARADDR;
            chk($sformatf("rd%0d_gnt", i), GNT_R, tbl[i].exp_gnt);
            chk($sformatf("rd%0d_arvalid", i), M_ARVALID, 1);
            chk($sformatf("rd%0d_araddr", i), M_ARADDR, exp_addr);
            M_ARREADY = 1'b1;
            #1;
            w_arready = (tbl[i].exp_gnt == 2'b01) ? S0_ARREADY : S1_ARREADY;
            l_arready = (tbl[i].exp_gnt == 2'b01) ? S1_ARREADY : S0_ARREADY;
            chk($sformatf("rd%0d_win_arready", i), w_arready, 1);
            chk($sformatf("rd%0d_lose_arready", i), l_arready, 0);
            step();
            M_ARREADY = 1'b0;
            if (tbl[i].exp_gnt == 2'b01) S0_ARVALID = 1'b0;
            else                         S1_ARVALID = 1'b0;
            M_RVALID = 1'b1;
            M_RDATA  = tbl[i].rdata;
            M_RRESP  = tbl[i].rresp;
            #1;
            w_rvalid = (tbl[i].exp_gnt == 2'b01) ? S0_RVALID : S1_RVALID;
            l_rvalid = (tbl[i].exp_gnt == 2'b01) ? S1_RVALID : S0_RVALID;
            w_rdata  = (tbl[i].exp_gnt == 2'b01) ? S0_RDATA  : S1_RDATA;
            w_rresp  = (tbl[i].exp_gnt == 2'b01) ? S0_RRESP  : S1_RRESP;
            chk($sformatf("rd%0d_win_rvalid", i), w_rvalid, 1);
            chk($sformatf("rd%0d_lose_rvalid", i), l_rvalid, 0);
            chk($sformatf("rd%0d_rdata", i), w_rdata, tbl[i].rdata);
            chk($sformatf("rd%0d_rresp", i), w_rresp, tbl[i].rresp);
            chk($sformatf("rd%0d_rready", i), M_RREADY, 1);
            step();
            M_RVALID = 1'b0;
        end
        step();
        chk("rd_done_gnt", GNT_R, 0);

        // single S0 write, OKAY response
        S0_AWADDR = 32'h2000_0010; S0_AWVALID = 1'b1;
        S0_WDATA = 32'hDEAD_BEEF; S0_WSTRB = 4'hF; S0_WVALID = 1'b1;
        #1;
        chk("wr_awvalid_before_grant", M_AWVALID, 0);
        step();
        chk("wr_gnt", GNT_W, 2'b01);
        chk("wr_awvalid", M_AWVALID, 1);
        chk("wr_awaddr", M_AWADDR, 32'h2000_0010);
        chk("wr_wvalid", M_WVALID, 1);
        chk("wr_wdata", M_WDATA, 32'hDEAD_BEEF);
        chk("wr_wstrb", M_WSTRB, 4'hF);
        M_AWREADY = 1'b1; M_WREADY = 1'b1;
        #1;
        chk("wr_s0_readys", {S0_AWREADY, S0_WREADY}, 2'b11);
        chk("wr_s1_readys", {S1_AWREADY, S1_WREADY}, 2'b00);
        step();
        M_AWREADY = 1'b0; M_WREADY = 1'b0; S0_AWVALID = 1'b0; S0_WVALID = 1'b0;
        M_BVALID = 1'b1; M_BRESP = 2'b00;
        #1;
        chk("wr_resp_awvalid", M_AWVALID, 0);
        chk("wr_s0_bvalid", S0_BVALID, 1);
        chk("wr_s0_bresp", S0_BRESP, 2'b00);
        chk("wr_s1_bvalid", S1_BVALID, 0);
        chk("wr_bready", M_BREADY, 1);
        step();
        M_BVALID = 1'b0;
        #1;
        chk("wr_done_gnt", GNT_W, 0);
        chk("wr_done_bvalid", S0_BVALID, 0);
        step();

        // concurrent S0 write and S1 read
        S0_AWADDR = 32'h2000_0030; S0_AWVALID = 1'b1;
        S0_WDATA = 32'h1234_5678; S0_WVALID = 1'b1;
        S1_ARADDR = 32'h4000_0000; S1_ARVALID = 1'b1;
        step();
        chk("cc_gnt_w", GNT_W, 2'b01);
        chk("cc_gnt_r", GNT_R, 2'b10);
        chk("cc_araddr", M_ARADDR, 32'h4000_0000);
        chk("cc_awaddr", M_AWADDR, 32'h2000_0030);
        chk("cc_valids", {M_AWVALID, M_WVALID, M_ARVALID}, 3'b111);
        M_AWREADY = 1'b1; M_WREADY = 1'b1; M_ARREADY = 1'b1;
        step();
        {M_AWREADY, M_WREADY, M_ARREADY} = '0;
        {S0_AWVALID, S0_WVALID, S1_ARVALID} = '0;
        M_BVALID = 1'b1; M_BRESP = 2'b00;
        M_RVALID = 1'b1; M_RDATA = 32'h2222_2222; M_RRESP = 2'b00;
        #1;
        chk("cc_s0_bvalid", S0_BVALID, 1);
        chk("cc_s1_bvalid", S1_BVALID, 0);
        chk("cc_s1_rvalid", S1_RVALID, 1);
        chk("cc_s0_rvalid", S0_RVALID, 0);
        chk("cc_s1_rdata", S1_RDATA, 32'h2222_2222);
        step();
        M_BVALID = 1'b0; M_RVALID = 1'b0;
        #1;
        chk("cc_done_gnts", {GNT_W, GNT_R}, 4'b0000);
        step();

        // W ahead of AW, slave takes W first; each channel forwarded exactly once
        aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        S0_WVALID = 1'b1; S0_WDATA = 32'hCAFE_F00D; S0_WSTRB = 4'h3;
        step();
        chk("wfirst_idle_gnt", GNT_W, 0);
        chk("wfirst_idle_wvalid", M_WVALID, 0);
        step();
        S0_AWVALID = 1'b1; S0_AWADDR = 32'h2000_0020; M_WREADY = 1'b1;
        step();
        chk("wfirst_gnt", GNT_W, 2'b01);
        chk("wfirst_valids", {M_AWVALID, M_WVALID}, 2'b11);
        chk("wfirst_readys", {S0_AWREADY, S0_WREADY}, 2'b01);
        step();
        chk("wfirst_w_gated", M_WVALID, 0);
        chk("wfirst_wready_gated", S0_WREADY, 0);
        chk("wfirst_aw_pending", M_AWVALID, 1);
        M_AWREADY = 1'b1;
        #1;
        chk("wfirst_awready", S0_AWREADY, 1);
        step();
        {M_AWREADY, M_WREADY, S0_AWVALID, S0_WVALID} = '0;
        M_BVALID = 1'b1; M_BRESP = 2'b10;
        #1;
        chk("wfirst_aw_hs_count", aw_hs_cnt - aw0, 1);
        chk("wfirst_w_hs_count", w_hs_cnt - w0, 1);
        chk("wfirst_resp_valids", {M_AWVALID, M_WVALID}, 2'b00);
        chk("wfirst_bvalid", {S0_BVALID, S1_BVALID}, 2'b10);
        chk("wfirst_bresp", S0_BRESP, 2'b10);
        step();
        M_BVALID = 1'b0;
        #1;
        chk("wfirst_done_gnt", GNT_W, 0);
        step();

        // reset while S1 holds the write grant in W_XFER
        S1_AWVALID = 1'b1; S1_AWADDR = 32'h3000_0000; S1_WVALID = 1'b1;
        step();
        chk("mrst_gnt_before", GNT_W, 2'b10);
        M_AWREADY = 1'b1; M_WREADY = 1'b1; ARESETN = 1'b0;
        step();
        chk("mrst_gnt_w", GNT_W, 0);
        chk("mrst_m_valids", {M_AWVALID, M_WVALID}, 2'b00);
        chk("mrst_readys", {S0_AWREADY, S0_WREADY, S1_AWREADY, S1_WREADY, S0_ARREADY, S1_ARREADY}, 0);
        S0_AWVALID = 1'b1; S0_WVALID = 1'b1; ARESETN = 1'b1;
        step();
        chk("mrst_tie_after_reset", GNT_W, 2'b01);
        ARESETN = 1'b0;
        {S0_AWVALID, S0_WVALID, S1_AWVALID, S1_WVALID, M_AWREADY, M_WREADY} = '0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
